// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32x32 multiply/divide unit with HI/LO registers,
// one bit per cycle, producing results 33 edges after an operation is accepted.
module muldiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        read_req,
  input  logic        read_sel,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dbz_q, dbz_d;
  logic [31:0] a_q, a_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_out_q, dbz_out_d;
  logic        sa, sb, zero;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] sum, sh;
  logic        ge;
  logic [63:0] mul_step, div_step, prod;
  assign sa = !op[0] && rs[31];
  assign sb = !op[0] && rt[31];
  assign abs_rs = sa ? -rs : rs;
  assign abs_rt = sb ? -rt : rt;
  assign zero = op[1] && (rt == 32'd0);
  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign sum = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? a_q : 32'd0};
  assign mul_step = {sum, acc_q[31:1]};
  assign sh = {acc_q[63:32], acc_q[31]};
  assign ge = sh >= {1'b0, a_q};
  assign div_step = {ge ? sh[31:0] - a_q : sh[31:0], acc_q[30:0], ge};
  assign prod = neg_q ? -acc_q : acc_q;
  assign busy = state_q != IDLE;
  assign stall = busy && (read_req || start);
  assign read_data = read_sel ? lo_q : hi_q;
  assign done = done_q;
  assign div_by_zero = dbz_out_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    is_div_d = is_div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dbz_d = dbz_q;
    a_d = a_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dbz_out_d = 1'b0;
    case (state_q)
      IDLE: if (start && !op[2]) begin
        is_div_d = op[1];
        dbz_d = zero;
        neg_d = !zero && (sa ^ sb);
        rneg_d = !zero && op[1] && sa;
        a_d = op[1] ? abs_rt : abs_rs;
        acc_d = zero ? {rs, 32'hFFFF_FFFF} : {32'd0, op[1] ? abs_rs : abs_rt};
        cnt_d = 6'd0;
        state_d = zero ? FIX : RUN;
      end
      RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? FIX : RUN;
      end
      FIX: begin
        hi_d = is_div_q ? (rneg_q ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
        lo_d = is_div_q ? (neg_q ? -acc_q[31:0] : acc_q[31:0]) : prod[31:0];
        done_d = 1'b1;
        dbz_out_d = dbz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q <= 1'b0;
      a_q <= 32'd0;
      acc_q <= 64'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      done_q <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      is_div_q <= is_div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dbz_q <= dbz_d;
      a_q <= a_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        read_req = 1'b0;
  logic        read_sel = 1'b0;
  logic [31:0] read_data;
  logic        busy, stall, done, div_by_zero;
  int n_chk = 0;
  int n_fail = 0;
  muldiv_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .read_req(read_req), .read_sel(read_sel), .read_data(read_data),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    rs = a;
    rt = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    chk(tag, n, exp_lat);
  endtask
  task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    read_sel = 1'b0;
    #1;
    chk({tag, "_hi"}, read_data, hi);
    read_sel = 1'b1;
    #1;
    chk({tag, "_lo"}, read_data, lo);
  endtask
  initial begin
    start = 1'b1;
    read_req = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk_hilo("rst", 32'd0, 32'd0);
    start = 1'b0;
    read_req = 1'b0;
    reset = 1'b0;
    issue(3'b011, 32'd100, 32'd7);
    chk("divu_busy", busy, 1'b1);
    wait_done("divu_lat", 33);
    chk("divu_dbz", div_by_zero, 1'b0);
    chk_hilo("divu", 32'd2, 32'd14);
    tick();
    chk("divu_done_pulse", done, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg_lat", 33);
    chk_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf_lat", 33);
    chk_hilo("div_ovf", 32'd0, 32'h8000_0000);
    issue(3'b000, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult_lat", 33);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'b001, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu_lat", 33);
    chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    issue(3'b010, 32'd5, 32'd0);
    wait_done("dbz_lat", 1);
    chk("dbz_flag", div_by_zero, 1'b1);
    chk_hilo("dbz", 32'd5, 32'hFFFF_FFFF);
    tick();
    chk("dbz_flag_clr", div_by_zero, 1'b0);
    chk("dbz_done_clr", done, 1'b0);
    issue(3'b100, 32'd9, 32'd3);
    chk("rsv_busy", busy, 1'b0);
    chk("rsv_done", done, 1'b0);
    chk("rsv_stall", stall, 1'b0);
    tick();
    chk("rsv_done2", done, 1'b0);
    issue(3'b001, 32'd3, 32'd4);
    repeat (5) tick();
    read_req = 1'b1;
    start = 1'b1;
    op = 3'b000;
    rs = 32'hFFFF_FFFE;
    rt = 32'd3;
    #1;
    chk("stall_on", stall, 1'b1);
    chk_hilo("stall_old", 32'd5, 32'hFFFF_FFFF);
    read_req = 1'b0;
    wait_done("stall_lat", 28);
    chk("stall_done_cycle", stall, 1'b0);
    chk_hilo("first_op", 32'd0, 32'd12);
    tick();
    start = 1'b0;
    chk("no_bubble_busy", busy, 1'b1);
    rs = 32'hDEAD_BEEF;
    rt = 32'h1234_5678;
    wait_done("second_lat", 33);
    chk_hilo("second_op", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk_hilo("mid_rst", 32'd0, 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_done", done, 1'b0);
    end
    issue(3'b001, 32'd2, 32'd3);
    chk("post_rst_busy", busy, 1'b1);
    wait_done("post_rst_lat", 33);
    chk_hilo("post_rst", 32'd0, 32'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Port list, in this order: name, direction, width, meaning.
- clock, in, 1: sole clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: operation request.
- op, in, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU; 1xx is reserved.
- rs, in, 32: multiplicand or dividend.
- rt, in, 32: multiplier or divisor.
- read_req, in, 1: MFHI/MFLO request.
- read_sel, in, 1: 0 selects HI, 1 selects LO.
- read_data, out, 32: selected HI/LO value.
- busy, out, 1: operation in flight.
- stall, out, 1: pipeline hold request.
- done, out, 1: completion pulse.
- div_by_zero, out, 1: divide-by-zero flag.
REQ-002 The block SHALL have one clock, "clock"; reset SHALL be "reset", asynchronous and active-high.

Function
REQ-003 FSM states SHALL be IDLE, RUN and FIX.
REQ-004 IDLE: start=1 with op in 000..011 SHALL, at that edge (E0), latch operand magnitudes and signs, clear the 6-bit iteration counter and go to RUN.
- Exception: DIV/DIVU with rt=0 SHALL go directly to FIX.
REQ-005 IDLE: start=1 with op=1xx SHALL be ignored; no state change, and busy, done and stall stay 0.
REQ-006 RUN SHALL process one bit per edge for exactly 32 edges (E1..E32), then go to FIX.
- MULT/MULTU: shift-add multiply.
- DIV/DIVU: restoring division.
REQ-007 FIX SHALL last one edge (E33).
- It writes HI/LO.
- It asserts done for the following cycle only.
- It returns to IDLE.
REQ-008 busy SHALL be 1 in RUN and FIX, and 0 in IDLE.
REQ-009 Latency: new HI/LO SHALL be visible on read_data in the cycle after E33 (the cycle after E1 for divide-by-zero).
REQ-010 MULT/MULTU results SHALL be HI = product[63:32] and LO = product[31:0].
- MULT is a signed 32x32 multiply.
- MULTU is an unsigned 32x32 multiply.
REQ-011 DIV/DIVU results SHALL be LO = quotient and HI = remainder.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-012 Divide by zero SHALL give HI = rs and LO = 0xFFFFFFFF, with div_by_zero=1 for the same cycle as done.
REQ-013 read_data SHALL always be combinational: HI when read_sel=0, LO when read_sel=1.
REQ-014 stall SHALL equal busy & (read_req | start), combinationally.
REQ-015 While busy:
- start SHALL be ignored; the requester holds start until stall drops.
- HI/LO SHALL hold their pre-operation values until the FIX edge.
REQ-016 In IDLE, start and read_req in the same cycle SHALL both proceed: the read returns the old HI/LO with stall=0, and the start is accepted.
REQ-017 In the done cycle (state IDLE), a new start SHALL be accepted with no bubble.
REQ-018 Operands SHALL be sampled only at E0; rs/rt changes during RUN SHALL have no effect.

Reset
REQ-019 reset=1 SHALL immediately, without waiting for a clock edge, set:
- state to IDLE and the counter to 0;
- HI=LO=0x00000000;
- busy=done=div_by_zero=0.
REQ-020 With reset=1, stall SHALL be 0 and read_data SHALL be 0x00000000.
REQ-021 Reset mid-operation SHALL discard the in-flight operation with no HI/LO update.
REQ-022 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- DIVU rs=100, rt=7 -> done exactly 33 edges after accept; HI=2, LO=14; div_by_zero=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT rs=0xFFFFFFFF, rt=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=5, rt=0 -> done after E1; HI=5, LO=0xFFFFFFFF, div_by_zero=1 for one cycle.
- During RUN, assert read_req=1 and start=1 (op=000) -> stall=1; read_data shows the old HI/LO; the second start is not accepted until the done cycle, then accepted with no bubble.
- Reset asserted mid-cycle during RUN iteration 10 -> busy=0 before the next edge; HI=LO=0; no done pulse.
